// File: rtl/layer_2_leaky_collector.sv
// -----------------------------------------------------------------------------
// layer_2_leaky_collector
//
// Purpose:
//    Serial-to-parallel stage feeding the 10-way argmax block. The 10 layer-2
//    neuron accumulator results arrive one per valid/ready handshake (neuron 1
//    first). Each result passes through a leaky ReLU and lands in its own
//    output register. After the 10th value the block pulses load for one
//    cycle, then freezes its outputs until the argmax stage reports max_done.
//
// Ports:
//    clk                       rising-edge clock, the only clock
//    reset                     synchronous, active-high reset
//    in_valid / in_data        signed accumulator result and its qualifier
//    in_ready                  high while collecting (value accepted on edge)
//    max_done                  completion from the argmax stage
//    load                      single-cycle pulse to the argmax stage
//    layer_2_output_leaky_N    leaky ReLU result for neuron N (N = 1..10)
//    frame_busy                high from first accept until max_done
//    timeout_err               sticky WAIT_DONE timeout flag
//
// Configuration:
//    LEAKY_TIMEOUT_EN  when defined, WAIT_DONE gives up after TIMEOUT_CYCLES
//                      cycles without max_done and sets timeout_err. When
//                      undefined, WAIT_DONE waits forever and timeout_err = 0.
// -----------------------------------------------------------------------------
module layer_2_leaky_collector #(
   parameter int INPUT_SIZE     = 81,
   parameter int LEAK_SHIFT     = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic signed [INPUT_SIZE-1:0] in_data,
   output logic                         in_ready,
   input  logic                         max_done,
   output logic                         load,
   output logic signed [INPUT_SIZE-1:0] layer_2_output_leaky_1,
   output logic signed [INPUT_SIZE-1:0] layer_2_output_leaky_2,
   output logic signed [INPUT_SIZE-1:0] layer_2_output_leaky_3,
   output logic signed [INPUT_SIZE-1:0] layer_2_output_leaky_4,
   output logic signed [INPUT_SIZE-1:0] layer_2_output_leaky_5,
   output logic signed [INPUT_SIZE-1:0] layer_2_output_leaky_6,
   output logic signed [INPUT_SIZE-1:0] layer_2_output_leaky_7,
   output logic signed [INPUT_SIZE-1:0] layer_2_output_leaky_8,
   output logic signed [INPUT_SIZE-1:0] layer_2_output_leaky_9,
   output logic signed [INPUT_SIZE-1:0] layer_2_output_leaky_10,
   output logic                         frame_busy,
   output logic                         timeout_err
);

   typedef enum logic [1:0] {
      COLLECT   = 2'd0,
      LOAD      = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAST_INDEX = 4'd9;

   state_t                        state_reg;
   logic [3:0]                    index_reg;
   logic                          in_ready_reg;
   logic                          load_reg;
   logic                          frame_busy_reg;
   logic                          accept;
   logic                          expired;
   logic signed [INPUT_SIZE-1:0]  leaky;
   logic signed [INPUT_SIZE-1:0]  out_val [10];

   // in_ready_reg is high exactly when state_reg == COLLECT, so accept can
   // only happen while collecting.
   assign accept = in_valid & in_ready_reg;

   // Arithmetic shift on a signed operand rounds toward minus infinity and
   // sign-extends; a negative input can only shrink in magnitude, so the
   // result always fits the input width.
   always_comb begin
      leaky = in_data;
      if (in_data[INPUT_SIZE-1]) begin
         leaky = in_data >>> LEAK_SHIFT;
      end
   end

   // Control FSM. load is registered: it is set on the edge that stores the
   // 10th value and cleared on the edge that leaves LOAD.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= COLLECT;
         index_reg      <= 4'd0;
         in_ready_reg   <= 1'b1;
         load_reg       <= 1'b0;
         frame_busy_reg <= 1'b0;
      end else begin
         load_reg <= 1'b0;
         case (state_reg)
            COLLECT: begin
               if (accept) begin
                  frame_busy_reg <= 1'b1;
                  if (index_reg == LAST_INDEX) begin
                     index_reg    <= 4'd0;
                     state_reg    <= LOAD;
                     in_ready_reg <= 1'b0;
                     load_reg     <= 1'b1;
                  end else begin
                     index_reg <= index_reg + 4'd1;
                  end
               end
            end
            LOAD: begin
               state_reg <= WAIT_DONE;
            end
            WAIT_DONE: begin
               // The argmax stage rereads the outputs every cycle until it
               // finishes, so nothing is written here.
               if (max_done || expired) begin
                  state_reg      <= COLLECT;
                  in_ready_reg   <= 1'b1;
                  frame_busy_reg <= 1'b0;
               end
            end
            default: begin
               state_reg    <= COLLECT;
               in_ready_reg <= 1'b1;
            end
         endcase
      end
   end

`ifdef LEAKY_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wait_cnt_reg;
   logic             timeout_err_reg;

   // Counter is 0 in the first WAIT_DONE cycle, so expiry lands on the
   // TIMEOUT_CYCLES-th WAIT_DONE cycle.
   assign expired = (state_reg == WAIT_DONE) && (wait_cnt_reg == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_reg    <= '0;
         timeout_err_reg <= 1'b0;
      end else if (state_reg != WAIT_DONE) begin
         wait_cnt_reg <= '0;
      end else begin
         wait_cnt_reg <= wait_cnt_reg + 1'b1;
         // A max_done coinciding with expiry is a normal completion.
         if (expired && !max_done) begin
            timeout_err_reg <= 1'b1;
         end
      end
   end

   assign timeout_err = timeout_err_reg;
`else
   logic unused_timeout_cfg;

   // Keeps the parameter referenced when the timeout logic is not built.
   assign unused_timeout_cfg = |TIMEOUT_CYCLES;
   assign expired            = 1'b0;
   assign timeout_err        = 1'b0;
`endif

   // One register per neuron; only the slot addressed by index_reg loads.
   for (genvar gi = 0; gi < 10; gi++) begin : g_out
      logic signed [INPUT_SIZE-1:0] val_reg;

      always_ff @(posedge clk) begin
         if (reset) begin
            val_reg <= '0;
         end else if (accept && (index_reg == 4'(gi))) begin
            val_reg <= leaky;
         end
      end

      assign out_val[gi] = val_reg;
   end

   assign in_ready                = in_ready_reg;
   assign load                    = load_reg;
   assign frame_busy              = frame_busy_reg;
   assign layer_2_output_leaky_1  = out_val[0];
   assign layer_2_output_leaky_2  = out_val[1];
   assign layer_2_output_leaky_3  = out_val[2];
   assign layer_2_output_leaky_4  = out_val[3];
   assign layer_2_output_leaky_5  = out_val[4];
   assign layer_2_output_leaky_6  = out_val[5];
   assign layer_2_output_leaky_7  = out_val[6];
   assign layer_2_output_leaky_8  = out_val[7];
   assign layer_2_output_leaky_9  = out_val[8];
   assign layer_2_output_leaky_10 = out_val[9];

endmodule

// File: doc/layer_2_leaky_collector.md
Name: layer_2_leaky_collector

Overview:
- Serial-to-parallel stage directly upstream of the 10-way argmax block.
- Accepts the 10 layer-2 neuron accumulator results one per handshake, applies leaky ReLU, and stores them in 10 output registers.
- Pulses load to the argmax stage, then holds its outputs stable until the argmax stage reports done.

Parameters:
- INPUT_SIZE, 81, width of each signed two's-complement accumulator value and each leaky output.
- LEAK_SHIFT, 3, arithmetic right-shift applied to negative values (slope 2^-LEAK_SHIFT).
- TIMEOUT_CYCLES, 255, WAIT_DONE timeout bound. Used only with LEAKY_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a valid accumulator result.
- in_data  input  INPUT_SIZE  signed layer-2 neuron result, neuron 1 first.
- in_ready  output  1  block accepts in_data this cycle.
- max_done  input  1  done from the argmax stage.
- load  output  1  single-cycle pulse to the argmax stage.
- layer_2_output_leaky_1 .. layer_2_output_leaky_10  output  INPUT_SIZE each  leaky ReLU results, neuron n on port n.
- frame_busy  output  1  high from first accepted value until max_done is received.
- timeout_err  output  1  sticky error flag. Tied 0 when LEAKY_TIMEOUT_EN is undefined.

Behaviour:
- Reset, synchronous and active-high, clears:
  - all 10 outputs to 0
  - load = 0, frame_busy = 0, timeout_err = 0
  - index counter to 0
  - state to COLLECT.
- Reset asserted mid-frame or mid-wait discards the partial frame. No load is issued.
- Leaky ReLU is combinational on in_data:
  - MSB = 0: value passes unchanged.
  - MSB = 1: result = in_data >>> LEAK_SHIFT, sign-extended, rounding toward minus infinity (-1 -> -1, -8 -> -1, -9 -> -2).
  - Output width equals input width; no overflow is possible.
- State COLLECT:
  - in_ready = 1.
  - Accept occurs when in_valid & in_ready at a clock edge. The leaky result is registered into output (index+1) and index increments.
  - frame_busy goes 1 on the first accept.
  - Accept at index 9: index wraps to 0, next state LOAD.
  - in_valid low: nothing changes, and outputs for unwritten indices keep their previous-frame values.
  - max_done in COLLECT is ignored.
- State LOAD:
  - Exactly one cycle; in_ready = 0, load = 1.
  - Next state WAIT_DONE.
  - load is registered, so it rises on the edge that stores value 10.
- State WAIT_DONE:
  - in_ready = 0.
  - All 10 outputs held constant, because the argmax stage resamples values 3..10 every cycle until it finishes.
  - On max_done = 1: next state COLLECT, frame_busy = 0.
  - A new frame may be accepted on the cycle after max_done.
  - End-to-end latency from the 10th accept edge to max_done is 3 cycles with the current argmax stage: load, then done_r, then done.
- Back-to-back frames:
  - Minimum period is 10 accept cycles + 1 LOAD + wait-for-done cycles.
  - No accept is possible while frame_busy is high after index 9.
- in_valid asserted while in_ready = 0: not accepted. Upstream must hold its data.

Optional Feature:
- LEAKY_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter runs in WAIT_DONE.
  - If max_done is not seen within TIMEOUT_CYCLES cycles: timeout_err sets (sticky until reset), state returns to COLLECT, frame_busy clears, outputs retained.
  - max_done arriving on the same cycle as expiry counts as success; no error is raised.
- LEAKY_TIMEOUT_EN undefined:
  - No counter is synthesized, timeout_err is constant 0, and WAIT_DONE waits indefinitely.

Test Plan:
- Reset then 10 accepts of values 1..10:
  - outputs 1..10 = 1..10
  - load high exactly one cycle, on the cycle after the 10th accept
  - the argmax model returns max = 10
  - frame_busy drops the cycle after max_done.
- Inputs -8, -1, -9, 0, 7, -16, 5, 2, -3, 4:
  - outputs -1, -1, -2, 0, 7, -2, 5, 2, -1, 4.
- Gappy in_valid (toggle every cycle) plus in_valid held high in WAIT_DONE:
  - only 10 accepts per frame
  - in_ready = 0 from LOAD until max_done
  - outputs unchanged throughout WAIT_DONE.
- Reset asserted after 6 accepts, then a full frame of 10:
  - no load from the aborted frame
  - second frame stored at indices 1..10 correctly.
- Two back-to-back frames with max_done delayed 5 cycles:
  - the second frame's first accept happens exactly one cycle after max_done
  - second frame values appear only after that accept.
- LEAKY_TIMEOUT_EN, TIMEOUT_CYCLES = 4, max_done never asserted:
  - timeout_err = 1 after 4 WAIT_DONE cycles, state back to COLLECT
  - next frame accepted, timeout_err stays 1 until reset.
